// File: rtl/pkt_dispatcher.sv
// pkt_dispatcher: writes a streamed packet into packet SRAM, runs the executor on it,
// then reports byte length and error status.
module pkt_dispatcher #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_WORDS = 512,
  parameter int EXEC_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last_i,
  input  logic [3:0]        s_sel_i,
  input  logic [ADDR_W-1:0] pkt_base_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_sel_o,
  output logic [DATA_W-1:0] sram_data_o,
  output logic              exec_start_o,
  output logic [ADDR_W-1:0] exec_start_addr_o,
  input  logic              exec_done_i,
  output logic              pkt_done_o,
  output logic [15:0]       pkt_len_o,
  output logic              err_o,
  output logic              busy_o
);
  typedef enum logic [2:0] {IDLE, WRITE, DRAIN, START, WAIT, RELEASE, DONE} state_t;
  localparam int CW = $clog2(EXEC_TIMEOUT + 1);
  state_t state;
  logic [ADDR_W-1:0] base;
  logic [15:0] words;
  logic [3:0] last_sel, sel;
  logic [CW-1:0] cnt;
  logic err, hs, wr, to_done;
  logic [18:0] len;
  assign hs = s_valid_i & s_ready_o;
  assign wr = hs & (state == IDLE | state == WRITE);
  assign sel = (s_last_i & s_sel_i != 4'h0) ? s_sel_i : 4'hf;
  assign to_done = (state == DRAIN & hs & s_last_i) | (state == RELEASE & cnt[0]);
  assign len = {1'b0, words, 2'b00} - 19'd4 + 19'($countones(last_sel));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      base <= '0;
      words <= '0;
      last_sel <= '0;
      cnt <= '0;
      err <= 1'b0;
      s_ready_o <= 1'b0;
      sram_ce_o <= 1'b0;
      sram_we_o <= 1'b0;
      sram_addr_o <= '0;
      sram_sel_o <= '0;
      sram_data_o <= '0;
      exec_start_o <= 1'b0;
      exec_start_addr_o <= '0;
      pkt_done_o <= 1'b0;
      pkt_len_o <= '0;
      err_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      sram_ce_o <= wr;
      sram_we_o <= wr;
      pkt_done_o <= to_done;
      if (wr) begin
        sram_addr_o <= state == IDLE ? pkt_base_i : base + ADDR_W'({words, 2'b00});
        sram_sel_o <= sel;
        sram_data_o <= s_data_i;
        last_sel <= sel;
        words <= (state == IDLE ? 16'd0 : words) + 16'd1;
      end
      if (to_done) begin
        pkt_len_o <= |len[18:16] ? 16'hffff : len[15:0];
        err_o <= err;
      end
      case (state)
        IDLE: begin
          s_ready_o <= 1'b1;
          if (hs) begin
            base <= pkt_base_i;
            exec_start_addr_o <= prog_addr_i;
            err <= (MAX_WORDS == 1) & !s_last_i;
            busy_o <= 1'b1;
            state <= MAX_WORDS == 1 ? DRAIN : WRITE;
          end
        end
        WRITE: if (hs & !s_last_i & ({16'd0, words} == 32'(MAX_WORDS - 1))) begin
          state <= DRAIN;
          err <= 1'b1;
        end
        START: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (exec_done_i | (32'(cnt) == EXEC_TIMEOUT - 1)) begin
          err <= err | !exec_done_i;
          exec_start_o <= 1'b0;
          cnt <= '0;
          state <= RELEASE;
        end else cnt <= cnt + 1'b1;
        RELEASE: cnt <= cnt + 1'b1;
        DONE: begin
          state <= IDLE;
          s_ready_o <= 1'b1;
          busy_o <= 1'b0;
        end
        default: state <= state;
      endcase
      // last word of an accepted packet launches the executor from IDLE or WRITE
      if (wr & s_last_i) begin
        state <= START;
        s_ready_o <= 1'b0;
        exec_start_o <= 1'b1;
      end
      if (to_done) begin
        state <= DONE;
        s_ready_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pkt_dispatcher.sv
// tb_pkt_dispatcher: table vectors, hand sequences and random packets checked against a packet-level model.
module tb_pkt_dispatcher;
  localparam int MAXW = 6;
  localparam int TO = 10;
  logic clk = 0, rst = 0;
  logic s_valid_i = 0, s_last_i = 0, exec_done_i = 0;
  logic [31:0] s_data_i = 0, pkt_base_i = 0, prog_addr_i = 0;
  logic [3:0] s_sel_i = 0;
  logic s_ready_o, sram_ce_o, sram_we_o, exec_start_o, pkt_done_o, err_o, busy_o;
  logic [31:0] sram_addr_o, sram_data_o, exec_start_addr_o;
  logic [3:0] sram_sel_o;
  logic [15:0] pkt_len_o;
  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
  typedef struct { int n; logic [31:0] base; logic [31:0] prog; logic [3:0] lsel; int d; bit gap; int len; bit err; } vec_t;
  wr_t wr_q [$];
  logic [31:0] sent [$];
  int done_cnt = 0, hi_cnt = 0, passed = 0, total = 0;
  logic [15:0] last_len = 0;
  logic last_err = 0;
  logic [31:0] last_saddr = 0;

  pkt_dispatcher #(.ADDR_W(32), .DATA_W(32), .MAX_WORDS(MAXW), .EXEC_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .s_last_i(s_last_i), .s_sel_i(s_sel_i), .pkt_base_i(pkt_base_i), .prog_addr_i(prog_addr_i),
    .sram_ce_o(sram_ce_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o), .sram_sel_o(sram_sel_o),
    .sram_data_o(sram_data_o), .exec_start_o(exec_start_o), .exec_start_addr_o(exec_start_addr_o),
    .exec_done_i(exec_done_i), .pkt_done_o(pkt_done_o), .pkt_len_o(pkt_len_o), .err_o(err_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sram_ce_o && sram_we_o) wr_q.push_back('{sram_addr_o, sram_data_o, sram_sel_o});
    if (pkt_done_o) begin
      done_cnt++;
      last_len = pkt_len_o;
      last_err = err_o;
    end
    if (exec_start_o) begin
      hi_cnt++;
      last_saddr = exec_start_addr_o;
    end
  end

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic send_words(input int n, input logic [31:0] base, input logic [31:0] prog,
                            input logic [3:0] lsel, input bit gap, input bit fixed);
    sent.delete();
    for (int i = 0; i < n; i++) begin
      int k;
      bit ok;
      s_valid_i = 0;
      if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      sent.push_back(fixed ? 32'hDEADBEEF + 32'(i) * 32'h11111111 : $urandom);
      s_valid_i = 1;
      s_data_i = sent[i];
      s_last_i = (i == n - 1);
      s_sel_i = (i == n - 1) ? lsel : 4'($urandom);
      pkt_base_i = (i == 0) ? base : $urandom;
      prog_addr_i = (i == 0) ? prog : $urandom;
      k = 0;
      do begin ok = s_ready_o; @(posedge clk); #1; k++; end while (!ok && k < 50);
      chk("stream_accept", ok, 1);
      exec_done_i = 0;
      if (!ok) break;
    end
    s_valid_i = 0;
    s_last_i = 0;
  endtask

  // xlen < 0 selects the packet-level model for length and error
  task automatic run_pkt(input int n, input logic [31:0] base, input logic [31:0] prog, input logic [3:0] lsel,
                         input int d, input bit gap, input bit fixed, input bit hold, input int xlen, input bit xerr);
    int w0, d0, h0, k, nw, hi, blen;
    bit berr;
    logic [3:0] le;
    w0 = wr_q.size();
    d0 = done_cnt;
    h0 = hi_cnt;
    send_words(n, base, prog, lsel, gap, fixed);
    if (n <= MAXW) begin
      k = 0;
      while (!exec_start_o && k < 50) begin @(posedge clk); #1; k++; end
      chk("exec_start_rise", exec_start_o, 1);
      if (d > 0) begin
        repeat (d) @(posedge clk);
        #1;
        exec_done_i = 1;
        if (!hold) begin @(posedge clk); #1; exec_done_i = 0; end
      end
    end
    k = 0;
    while (done_cnt == d0 && k < 80) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    le = (lsel == 4'h0) ? 4'hf : lsel;
    nw = n < MAXW ? n : MAXW;
    blen = n <= MAXW ? 4 * (n - 1) + $countones(le) : 4 * MAXW;
    berr = n > MAXW || d < 1 || d > TO;
    hi = n > MAXW ? 0 : (d >= 1 && d <= TO) ? d + 1 : TO + 1;
    chk("write_count", wr_q.size() - w0, nw);
    for (int i = 0; i < nw && w0 + i < wr_q.size(); i++)
      chk("write", {wr_q[w0+i].a, wr_q[w0+i].d, wr_q[w0+i].s},
          {base + 32'(4 * i), sent[i], (i == n - 1) ? le : 4'hf});
    chk("done_pulses", done_cnt - d0, 1);
    chk("pkt_len", last_len, xlen >= 0 ? xlen : blen);
    chk("err", last_err, xlen >= 0 ? xerr : berr);
    chk("start_cycles", hi_cnt - h0, hi);
    if (n <= MAXW) chk("start_addr", last_saddr, prog);
    chk("idle_state", {busy_o, s_ready_o, exec_start_o}, 3'b010);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    int k, d0;
    tbl[0] = '{1, 32'h100, 32'h800, 4'b1100, 3, 0, 2, 0};
    tbl[1] = '{5, 32'h40, 32'h200, 4'b1111, 2, 1, 20, 0};
    tbl[2] = '{8, 32'h1000, 32'h300, 4'b0011, 0, 0, 24, 1};
    tbl[3] = '{3, 32'h2000, 32'h400, 4'b0000, 5, 1, 12, 0};
    tbl[4] = '{6, 32'h3000, 32'h500, 4'b0001, 1, 0, 21, 0};
    tbl[5] = '{2, 32'h4000, 32'h600, 4'b0111, 0, 1, 7, 1};
    tbl[6] = '{7, 32'h5000, 32'h700, 4'b1111, 4, 1, 24, 1};
    tbl[7] = '{2, 32'h6000, 32'h900, 4'b1000, 9, 0, 5, 0};
    #12;
    chk("reset_outputs", {s_ready_o, busy_o, exec_start_o, sram_ce_o, sram_we_o, pkt_done_o, err_o,
                          pkt_len_o, exec_start_addr_o, sram_addr_o}, 0);
    rst = 1;
    @(posedge clk); #1;
    chk("ready_after_reset", {s_ready_o, busy_o}, 2'b10);
    foreach (tbl[i])
      run_pkt(tbl[i].n, tbl[i].base, tbl[i].prog, tbl[i].lsel, tbl[i].d, tbl[i].gap, 1, 0, tbl[i].len, tbl[i].err);
    // done held high through RELEASE into the next packet's WRITE
    run_pkt(2, 32'h7000, 32'hA00, 4'b1111, 3, 0, 0, 1, 8, 0);
    run_pkt(3, 32'h7100, 32'hB00, 4'b0110, 4, 1, 0, 0, 10, 0);
    for (int r = 0; r < 20; r++) begin
      int n, d;
      n = $urandom_range(1, MAXW + 2);
      d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO - 1);
      run_pkt(n, $urandom, $urandom, 4'($urandom), d, 1'($urandom_range(0, 1)), 0, 0, -1, 0);
    end
    // asynchronous reset while the executor is running
    d0 = done_cnt;
    send_words(2, 32'h8000, 32'hC00, 4'hf, 0, 0);
    k = 0;
    while (!exec_start_o && k < 50) begin @(posedge clk); #1; k++; end
    repeat (3) begin @(posedge clk); #1; end
    chk("wait_before_rst", {exec_start_o, busy_o}, 2'b11);
    #2 rst = 0;
    #1;
    chk("rst_async", {exec_start_o, busy_o, s_ready_o}, 3'b000);
    #3 rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_recover_ready", {s_ready_o, busy_o}, 2'b10);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_len_cleared", {err_o, pkt_len_o}, 0);
    run_pkt(4, 32'h9000, 32'hD00, 4'b0010, 2, 1, 0, 0, -1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
